prbs_word_gen: RTL and testbench
================================

# prbs_word_gen

Parametrised multi-polynomial PRBS generator producing W bits per clock behind a valid/ready handshake. It succeeds the fixed single-bit PRBS7 source and feeds link BIST, SerDes lane test and memory pattern paths. It supports runtime polynomial selection, seed loading, all-zero lock-up recovery and back-pressure without sequence loss.

## Interface
- `W`, default 8: output word width, 1..64.
- `SEED`, default 31'h7FFF_FFFF: reset seed, masked to the active polynomial length.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: generation enable.
- `load` input 1: single-cycle pulse; loads `seed` and latches `mode`.
- `mode` input 3: polynomial select. 0 PRBS7 x^7+x^6+1. 1 PRBS9 x^9+x^5+1. 2 PRBS15 x^15+x^14+1. 3 PRBS23 x^23+x^18+1. 4 PRBS31 x^31+x^28+1. 5–7 are reserved and map to PRBS7.
- `seed` input 31: seed value; the low N bits are used.
- `out_data` output W: generated word; bit 0 is the oldest bit.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer accepts the word.
- `word_cnt` output 32: count of accepted words, wrapping.

## Operation
- State `s[30:0]`. N is the length of the latched mode and T is its lower tap.
- One step:
  - b = s[N-1] ^ s[T-1]
  - s[N-1:0] <= {s[N-2:0], b}
  - the emitted bit is b
  - s[30:N] is held at 0
- A word is W consecutive steps, unrolled combinationally. Bit 0 of the word is the first step.
- Generate condition: `en` && (!`out_valid` || `out_ready`). When it is true:
  - `out_data` <= next word
  - the state advances W steps
  - `out_valid` <= 1
- Hold condition: `out_valid` && !`out_ready`. `out_data` and the state are frozen regardless of `en`. A presented word is never dropped or changed.
- `en` low with no pending word: `out_valid` <= 0 once the current word is accepted.
- `load` has priority over generation:
  - state <= `seed` masked to N
  - mode latch <= `mode`
  - `out_valid` <= 0
- `load` coincident with acceptance: the handshake still counts, so `word_cnt` increments, and the pending word is retired.
- Lock-up: if the masked seed or the reset seed is all-zero, the state is forced to all-ones of length N.
- `mode` is sampled only on `load`. Changing it at any other time has no effect.
- `word_cnt` increments on every `out_valid` && `out_ready` and wraps 2^32-1 → 0. `load` does not clear it.

## Timing
- Reset values:
  - mode latch = 0 (PRBS7)
  - state = `SEED` masked to 7 bits, with the all-zero substitution
  - `out_valid` = 0
  - `out_data` = 0
  - `word_cnt` = 0
- First word: `out_valid` rises on the clock edge following the first cycle with `en`=1 after reset or `load`. Latency is 1 cycle.
- Sustained throughput is one word per cycle with `out_ready` held at 1.
- `rst_n` asserted mid-stream clears all outputs immediately, asynchronously. Release is synchronous to `clk`, handled by an upstream synchroniser.
- Period: PRBS-N repeats after 2^N−1 bits. For W coprime to 2^N−1, the word stream repeats after 2^N−1 words.

## Configuration
- `PRBS_ERR_INJ_EN` defined:
  - adds an `err_inj` input (1 bit)
  - if `err_inj` is high in a generate cycle, bit 0 of the generated `out_data` is inverted
  - the LFSR state is unaffected, so a downstream checker sees a single-bit error and stays locked
- `PRBS_ERR_INJ_EN` undefined: the port is absent and there is no inversion logic.

## Structure
- Package `prbs_pkg` holds:
  - the `prbs_mode_e` enum
  - per-mode constants N and T
  - `PRBS_STATE_W` = 31
  - a `prbs_step` function
- One sub-module, `prbs_word_step`, is combinational. It takes state, mode and W, returns the next state and the W-bit word, and is reused by the planned checker.

## Test plan
- Reset, PRBS7, `SEED` all-ones, W=8, `en`=1, `out_ready`=1 → first `out_data` = 8'h40 (bits 0,0,0,0,0,0,1,0); state returns to 7'h7F after 127 words.
- `load` with `mode`=4 and `seed`=0 → state forced to 31'h7FFF_FFFF; `out_valid` low for 1 cycle, then the PRBS31 stream matches the golden model for 10k words.
- `out_ready` low for 5 cycles mid-stream → `out_data` stable and `word_cnt` frozen; the sequence continues with no gap or repeat.
- `load` coincident with acceptance → `word_cnt` increments by 1; the next word comes from the new seed.
- `rst_n` pulsed low mid-stream for 3 ns, asynchronously → `out_valid`=0 and `word_cnt`=0 immediately; on restart the stream matches the reset-seed sequence.
- With `PRBS_ERR_INJ_EN`, `err_inj` high for one word → exactly bit 0 of that word differs from the model; the following words match.

Source files
------------

// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS word generator and its companion checker:
// polynomial selector enum, per-polynomial length (N) and lower tap (T),
// the state width, and the single-step LFSR helper functions.
// No ports (package).
// -----------------------------------------------------------------------------
package prbs_pkg;

    localparam int PRBS_STATE_W = 31;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_e;

    // Polynomial length N and lower tap T for x^N + x^T + 1
    localparam int PRBS7_N  = 7;
    localparam int PRBS7_T  = 6;
    localparam int PRBS9_N  = 9;
    localparam int PRBS9_T  = 5;
    localparam int PRBS15_N = 15;
    localparam int PRBS15_T = 14;
    localparam int PRBS23_N = 23;
    localparam int PRBS23_T = 18;
    localparam int PRBS31_N = 31;
    localparam int PRBS31_T = 28;

    // Raw 3-bit selector to polynomial; reserved codes fall back to PRBS7.
    function automatic prbs_mode_e prbs_mode_decode(input logic [2:0] sel);
        prbs_mode_e m;
        case (sel)
            3'd1:    m = PRBS9;
            3'd2:    m = PRBS15;
            3'd3:    m = PRBS23;
            3'd4:    m = PRBS31;
            default: m = PRBS7;
        endcase
        return m;
    endfunction

    // Mask covering the low N bits of the state for the given polynomial.
    function automatic logic [PRBS_STATE_W-1:0] prbs_mask(input prbs_mode_e m);
        logic [PRBS_STATE_W-1:0] msk;
        case (m)
            PRBS9:   msk = 31'h0000_01FF;
            PRBS15:  msk = 31'h0000_7FFF;
            PRBS23:  msk = 31'h007F_FFFF;
            PRBS31:  msk = 31'h7FFF_FFFF;
            default: msk = 31'h0000_007F;
        endcase
        return msk;
    endfunction

    // Seed masked to N bits; an all-zero result would lock the LFSR, so it
    // is replaced by all-ones of length N.
    function automatic logic [PRBS_STATE_W-1:0] prbs_seed_fix(
        input logic [PRBS_STATE_W-1:0] sd,
        input prbs_mode_e              m
    );
        logic [PRBS_STATE_W-1:0] msk;
        logic [PRBS_STATE_W-1:0] masked;
        msk    = prbs_mask(m);
        masked = sd & msk;
        if (masked == 31'h0000_0000) begin
            masked = msk;
        end else begin
            masked = sd & msk;
        end
        return masked;
    endfunction

    // One LFSR step. The new feedback bit lands in bit 0 of the returned
    // state, so the emitted bit of this step is simply result[0].
    function automatic logic [PRBS_STATE_W-1:0] prbs_step(
        input logic [PRBS_STATE_W-1:0] s,
        input prbs_mode_e              m
    );
        logic fb;
        case (m)
            PRBS9:   fb = s[PRBS9_N-1]  ^ s[PRBS9_T-1];
            PRBS15:  fb = s[PRBS15_N-1] ^ s[PRBS15_T-1];
            PRBS23:  fb = s[PRBS23_N-1] ^ s[PRBS23_T-1];
            PRBS31:  fb = s[PRBS31_N-1] ^ s[PRBS31_T-1];
            default: fb = s[PRBS7_N-1]  ^ s[PRBS7_T-1];
        endcase
        // Bits above N are cleared so s[30:N] stays at zero.
        return {s[PRBS_STATE_W-2:0], fb} & prbs_mask(m);
    endfunction

endpackage : prbs_pkg

// File: rtl/prbs_word_step.sv
// -----------------------------------------------------------------------------
// prbs_word_step
// Combinational W-step unroll of the PRBS LFSR. Shared by the generator and
// the downstream checker so both walk the sequence identically.
// Ports:
//   state_in   [30:0]  current LFSR state
//   mode               active polynomial
//   state_out  [30:0]  state after W steps
//   word_out   [W-1:0] emitted bits, bit 0 = first (oldest) step
// -----------------------------------------------------------------------------
module prbs_word_step
    import prbs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [PRBS_STATE_W-1:0] state_in,
    input  prbs_mode_e              mode,
    output logic [PRBS_STATE_W-1:0] state_out,
    output logic [W-1:0]            word_out
);

    logic [PRBS_STATE_W-1:0] st_s;
    logic [W-1:0]            word_s;

    // Unroll W single steps; each step's emitted bit is the new state bit 0.
    always_comb begin
        st_s   = state_in;
        word_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            st_s      = prbs_step(st_s, mode);
            word_s[i] = st_s[0];
        end
        state_out = st_s;
        word_out  = word_s;
    end

endmodule : prbs_word_step

// File: rtl/prbs_word_gen.sv
// -----------------------------------------------------------------------------
// prbs_word_gen
// Multi-polynomial PRBS source (PRBS7/9/15/23/31) emitting W bits per clock
// behind a valid/ready handshake, with runtime seed/polynomial load, all-zero
// lock-up recovery and lossless back-pressure.
// Optional build macro PRBS_ERR_INJ_EN adds the err_inj input, which inverts
// bit 0 of a generated word without disturbing the LFSR state.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   en                  generation enable
//   load                one-cycle pulse: load seed, latch mode
//   mode      [2:0]     polynomial select (5..7 behave as PRBS7)
//   seed      [30:0]    seed, low N bits used
//   err_inj             (PRBS_ERR_INJ_EN only) flip bit 0 of the next word
//   out_data  [W-1:0]   generated word, bit 0 oldest
//   out_valid           out_data valid
//   out_ready           consumer accepts word
//   word_cnt  [31:0]    accepted-word count, wrapping
// -----------------------------------------------------------------------------
module prbs_word_gen
    import prbs_pkg::*;
#(
    parameter int                      W    = 8,
    parameter logic [PRBS_STATE_W-1:0] SEED = 31'h7FFF_FFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [2:0]              mode,
    input  logic [PRBS_STATE_W-1:0] seed,
`ifdef PRBS_ERR_INJ_EN
    input  logic                    err_inj,
`endif
    output logic [W-1:0]            out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             word_cnt
);

    logic [PRBS_STATE_W-1:0] state_r;
    prbs_mode_e              mode_r;

    logic [PRBS_STATE_W-1:0] next_state_s;
    logic [W-1:0]            next_word_s;
    logic [W-1:0]            gen_word_s;
    logic                    accept_s;
    logic                    gen_s;

    prbs_word_step #(
        .W (W)
    ) u_step (
        .state_in  (state_r),
        .mode      (mode_r),
        .state_out (next_state_s),
        .word_out  (next_word_s)
    );

    // Handshake: accept when a word is presented and taken; generate only
    // when the output slot is empty or being emptied this cycle.
    assign accept_s = out_valid & out_ready;
    assign gen_s    = en & (~out_valid | out_ready);

`ifdef PRBS_ERR_INJ_EN
    // Error injection touches only the emitted word, never the LFSR state.
    always_comb begin
        gen_word_s    = next_word_s;
        gen_word_s[0] = next_word_s[0] ^ err_inj;
    end
`else
    // Emitted word is the unrolled LFSR output unchanged.
    always_comb begin
        gen_word_s = next_word_s;
    end
`endif

    // Generator state, output register and accepted-word counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= prbs_seed_fix(SEED, PRBS7);
            mode_r    <= PRBS7;
            out_data  <= {W{1'b0}};
            out_valid <= 1'b0;
            word_cnt  <= 32'd0;
        end else begin
            // The handshake counts even when a load retires the word.
            if (accept_s) begin
                word_cnt <= word_cnt + 32'd1;
            end else begin
                word_cnt <= word_cnt;
            end

            if (load) begin
                state_r   <= prbs_seed_fix(seed, prbs_mode_decode(mode));
                mode_r    <= prbs_mode_decode(mode);
                out_valid <= 1'b0;
            end else if (gen_s) begin
                state_r   <= next_state_s;
                out_data  <= gen_word_s;
                out_valid <= 1'b1;
            end else if (accept_s) begin
                out_valid <= 1'b0;
            end else begin
                // Either idle or holding a presented word under back-pressure.
                out_valid <= out_valid;
            end
        end
    end

endmodule : prbs_word_gen

// File: tb/tb_prbs_word_gen.sv
// -----------------------------------------------------------------------------
// tb_prbs_word_gen
// Scoreboard bench for prbs_word_gen (W=8). An independent LFSR model predicts
// each generated word at drive time and queues it; words are popped and
// compared when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_prbs_word_gen;

    localparam int W = 8;
    localparam logic [30:0] RST_SEED = 31'h7FFF_FFFF;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [2:0]    mode;
    logic [30:0]   seed;
    logic          err_inj;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   word_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [30:0]   m_state;
    logic [30:0]   m_mask;
    int            m_n;
    int            m_t;
    logic          m_valid;
    logic [31:0]   m_cnt;
    int            m_words;
    logic          m_p7_ref;
    logic [W-1:0]  sb_q[$];

    prbs_word_gen #(
        .W    (W),
        .SEED (RST_SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .mode      (mode),
        .seed      (seed),
`ifdef PRBS_ERR_INJ_EN
        .err_inj   (err_inj),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_load(input logic [2:0] md, input logic [30:0] sd);
        case (md)
            3'd1:    begin m_n = 9;  m_t = 5;  end
            3'd2:    begin m_n = 15; m_t = 14; end
            3'd3:    begin m_n = 23; m_t = 18; end
            3'd4:    begin m_n = 31; m_t = 28; end
            default: begin m_n = 7;  m_t = 6;  end
        endcase
        for (int k = 0; k < 31; k++) m_mask[k] = (k < m_n);
        m_state = sd & m_mask;
        if (m_state == 31'd0) m_state = m_mask;
    endtask

    task automatic model_word(output logic [W-1:0] w);
        logic [4:0] ni;
        logic [4:0] ti;
        logic       b;
        ni = 5'(m_n - 1);
        ti = 5'(m_t - 1);
        for (int i = 0; i < W; i++) begin
            b       = m_state[ni] ^ m_state[ti];
            m_state = ((m_state << 1) | {30'd0, b}) & m_mask;
            w[i]    = b;
        end
    endtask

    task automatic model_reset();
        model_load(3'd0, RST_SEED);
        sb_q.delete();
        m_valid  = 1'b0;
        m_cnt    = 32'd0;
        m_words  = 0;
        m_p7_ref = 1'b1;
    endtask

    // Called at the falling edge: compare outputs, then predict the next edge.
    task automatic sb_step();
        logic [W-1:0] w;
        logic         inj;
        check_val("valid", 64'(out_valid), 64'(m_valid));
        check_val("word_cnt", 64'(word_cnt), 64'(m_cnt));
        if (m_valid) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
            end else begin
                check_val("data", 64'(out_data), 64'(sb_q[0]));
            end
        end
        if (m_valid && out_ready) begin
            if (m_p7_ref && (m_words == 0 || m_words == 127))
                check_val("prbs7_ref_word", 64'(out_data), 64'h40);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            m_cnt   = m_cnt + 32'd1;
            m_words = m_words + 1;
        end
        inj = 1'b0;
`ifdef PRBS_ERR_INJ_EN
        inj = err_inj;
`endif
        if (load) begin
            model_load(mode, seed);
            sb_q.delete();
            m_valid  = 1'b0;
            m_p7_ref = 1'b0;
        end else if (en && (!m_valid || out_ready)) begin
            model_word(w);
            if (inj) w[0] = ~w[0];
            sb_q.push_back(w);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        mode      = 3'd0;
        seed      = 31'd0;
        err_inj   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_data", 64'(out_data), 64'd0);
        check_val("rst_cnt", 64'(word_cnt), 64'd0);

        // PRBS7 from reset seed, sustained throughput, period wrap at 127 words
        en = 1'b1; out_ready = 1'b1;
        repeat (140) tick();

        // back-pressure mid-stream
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (10) tick();

        // mode changes without load are ignored
        mode = 3'd3;
        repeat (5) tick();

        // en low: pending word held under back-pressure, then drained
        en = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();
        en = 1'b1;
        repeat (3) tick();

        // PRBS31 with zero seed (lock-up substitution), coincident with accept
        load = 1'b1; mode = 3'd4; seed = 31'd0;
        tick();
        load = 1'b0; mode = 3'd0;
        repeat (10000) tick();

        // load coincident with acceptance, PRBS9
        load = 1'b1; mode = 3'd1; seed = 31'h0000_0ABC;
        tick();
        load = 1'b0;
        repeat (30) tick();

        // reserved mode behaves as PRBS7
        load = 1'b1; mode = 3'd6; seed = 31'h0001_2345;
        tick();
        load = 1'b0;
        repeat (20) tick();

        // PRBS15 and PRBS23 under random enable / back-pressure
        load = 1'b1; mode = 3'd2; seed = 31'h0000_1357;
        tick();
        load = 1'b0;
        repeat (150) begin
            en        = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        load = 1'b1; mode = 3'd3; seed = 31'h0055_AA33;
        tick();
        load = 1'b0;
        repeat (150) begin
            en        = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        en = 1'b1; out_ready = 1'b1;
        repeat (5) tick();

        // asynchronous reset pulse mid-stream
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_cnt", 64'(word_cnt), 64'd0);
        check_val("async_rst_data", 64'(out_data), 64'd0);
        model_reset();
        #2 rst_n = 1'b1;
        repeat (20) tick();

`ifdef PRBS_ERR_INJ_EN
        err_inj = 1'b1;
        tick();
        err_inj = 1'b0;
        repeat (6) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prbs_word_gen
